// File: rtl/stream_upsizer.sv
// Narrow-to-wide stream packer: collects RATIO beats of IN_W bits into one output word.
// Handles early flush on s_last with a per-lane keep mask and valid/ready flow control on both sides.
module stream_upsizer #(
  parameter int IN_W      = 4,
  parameter int RATIO     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [IN_W-1:0]            s_data,
  input  logic                       s_valid,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [IN_W*RATIO-1:0]      m_data,
  output logic [RATIO-1:0]           m_keep,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(RATIO)-1:0]   lane_cnt
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO);

  logic [OUT_W-1:0] acc_data_p0;
  logic [RATIO-1:0] acc_keep_p0;

  logic [CW-1:0]    lane_idx;
  logic [OUT_W-1:0] merged_data;
  logic [RATIO-1:0] merged_keep;
  logic             last_lane;
  logic             out_free;
  logic             beat_acc;
  logic             completing;

  // Physical lane that the beat at accumulation position cnt lands in.
  function automatic logic [CW-1:0] lane_of(input logic [CW-1:0] cnt);
    if (LSB_FIRST != 0)
      lane_of = cnt;
    else
      lane_of = CW'(RATIO - 1) - cnt;
  endfunction

  assign lane_idx   = lane_of(lane_cnt);
  assign last_lane  = (lane_cnt == CW'(RATIO - 1));
  assign out_free   = !m_valid || m_ready;
  // A completing beat needs the output slot; any other beat only touches the accumulator.
  assign s_ready    = out_free || (!last_lane && !s_last);
  assign beat_acc   = s_valid && s_ready;
  assign completing = beat_acc && (last_lane || s_last);

  always_comb begin
    merged_data = acc_data_p0;
    merged_keep = acc_keep_p0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_idx == CW'(i)) begin
        merged_data[i*IN_W +: IN_W] = s_data;
        merged_keep[i]              = 1'b1;
      end
    end
  end

  // Stage p0: accumulator of the word being assembled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_data_p0 <= '0;
      acc_keep_p0 <= '0;
      lane_cnt    <= '0;
    end else if (completing) begin
      acc_data_p0 <= '0;
      acc_keep_p0 <= '0;
      lane_cnt    <= '0;
    end else if (beat_acc) begin
      acc_data_p0 <= merged_data;
      acc_keep_p0 <= merged_keep;
      lane_cnt    <= lane_cnt + CW'(1);
    end
  end

  // Stage p1: output register, replaced in place when a new word completes as the old one leaves
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (completing) begin
      m_valid <= 1'b1;
      m_data  <= merged_data;
      m_keep  <= merged_keep;
      m_last  <= s_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer: an LSB-first and an MSB-first instance (IN_W=4, RATIO=4)
// driven with hand-computed vectors.
module tb_stream_upsizer;

  logic        clk;
  logic        rstn;
  logic [3:0]  s_data   [2];
  logic        s_valid  [2];
  logic        s_last   [2];
  logic        s_ready  [2];
  logic [15:0] m_data   [2];
  logic [3:0]  m_keep   [2];
  logic        m_last   [2];
  logic        m_valid  [2];
  logic        m_ready  [2];
  logic [1:0]  lane_cnt [2];

  int total = 0;
  int bad   = 0;

  stream_upsizer #(.IN_W(4), .RATIO(4), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rstn(rstn),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]), .s_ready(s_ready[0]),
    .m_data(m_data[0]), .m_keep(m_keep[0]), .m_last(m_last[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready[0]), .lane_cnt(lane_cnt[0])
  );

  stream_upsizer #(.IN_W(4), .RATIO(4), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rstn(rstn),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]), .s_ready(s_ready[1]),
    .m_data(m_data[1]), .m_keep(m_keep[1]), .m_last(m_last[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready[1]), .lane_cnt(lane_cnt[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Entered 1 time unit after a rising edge; returns 1 unit after the edge that accepted the beat.
  task automatic beat(input int u, input logic [3:0] d, input logic last, output int waits);
    s_data[u]  = d;
    s_valid[u] = 1'b1;
    s_last[u]  = last;
    waits = 0;
    #1;
    while (!s_ready[u] && waits < 20) begin
      @(posedge clk);
      #1;
      waits++;
    end
    if (waits >= 20) chk_eq("accept_timeout", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
    s_valid[u] = 1'b0;
    s_last[u]  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int wsum;
    rstn = 1'b1;
    for (int u = 0; u < 2; u++) begin
      s_data[u] = '0; s_valid[u] = 1'b0; s_last[u] = 1'b0; m_ready[u] = 1'b1;
    end
    #3 rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_eq("rst_m_valid", 32'(m_valid[0]), 32'd0);
    chk_eq("rst_m_data", 32'(m_data[0]), 32'h0);
    chk_eq("rst_m_keep", 32'(m_keep[0]), 32'h0);
    chk_eq("rst_m_last", 32'(m_last[0]), 32'd0);
    chk_eq("rst_lane_cnt", 32'(lane_cnt[0]), 32'd0);
    rstn = 1'b1;

    // Full word, LSB first
    beat(0, 4'h1, 1'b0, w);
    chk_eq("lsb_lane_cnt1", 32'(lane_cnt[0]), 32'd1);
    chk_eq("lsb_no_early_valid", 32'(m_valid[0]), 32'd0);
    beat(0, 4'h2, 1'b0, w);
    beat(0, 4'h3, 1'b0, w);
    beat(0, 4'h4, 1'b0, w);
    chk_eq("full_valid", 32'(m_valid[0]), 32'd1);
    chk_eq("full_data", 32'(m_data[0]), 32'h4321);
    chk_eq("full_keep", 32'(m_keep[0]), 32'hF);
    chk_eq("full_last", 32'(m_last[0]), 32'd0);
    chk_eq("full_lane_cnt", 32'(lane_cnt[0]), 32'd0);
    idle_cycle();
    chk_eq("full_consumed", 32'(m_valid[0]), 32'd0);

    // MSB first, then a continuous 8-beat stream
    beat(1, 4'h1, 1'b0, w);
    beat(1, 4'h2, 1'b0, w);
    beat(1, 4'h3, 1'b0, w);
    beat(1, 4'h4, 1'b0, w);
    chk_eq("msb_data", 32'(m_data[1]), 32'h1234);
    chk_eq("msb_keep", 32'(m_keep[1]), 32'hF);
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      beat(1, 4'(5 + i), 1'b0, w);
      wsum += w;
      if (i == 3) begin
        chk_eq("msb_w1_valid", 32'(m_valid[1]), 32'd1);
        chk_eq("msb_w1_data", 32'(m_data[1]), 32'h5678);
      end
    end
    chk_eq("msb_w2_valid", 32'(m_valid[1]), 32'd1);
    chk_eq("msb_w2_data", 32'(m_data[1]), 32'h9ABC);
    chk_eq("msb_stream_stalls", 32'(wsum), 32'd0);
    idle_cycle();

    // Partial flush on s_last
    beat(0, 4'hA, 1'b0, w);
    beat(0, 4'hB, 1'b1, w);
    chk_eq("flush_valid", 32'(m_valid[0]), 32'd1);
    chk_eq("flush_data", 32'(m_data[0]), 32'h00BA);
    chk_eq("flush_keep", 32'(m_keep[0]), 32'h3);
    chk_eq("flush_last", 32'(m_last[0]), 32'd1);
    chk_eq("flush_lane_cnt", 32'(lane_cnt[0]), 32'd0);
    beat(0, 4'hC, 1'b0, w);
    chk_eq("after_flush_cnt", 32'(lane_cnt[0]), 32'd1);
    beat(0, 4'hD, 1'b1, w);
    chk_eq("after_flush_data", 32'(m_data[0]), 32'h00DC);
    chk_eq("after_flush_keep", 32'(m_keep[0]), 32'h3);
    idle_cycle();

    // Backpressure
    beat(0, 4'h1, 1'b0, w);
    beat(0, 4'h2, 1'b0, w);
    beat(0, 4'h3, 1'b0, w);
    beat(0, 4'h4, 1'b0, w);
    chk_eq("bp_first_data", 32'(m_data[0]), 32'h4321);
    m_ready[0] = 1'b0;
    wsum = 0;
    beat(0, 4'h5, 1'b0, w); wsum += w;
    beat(0, 4'h6, 1'b0, w); wsum += w;
    beat(0, 4'h7, 1'b0, w); wsum += w;
    chk_eq("bp_first3_stalls", 32'(wsum), 32'd0);
    chk_eq("bp_lane_cnt", 32'(lane_cnt[0]), 32'd3);
    s_data[0] = 4'h8; s_valid[0] = 1'b1; s_last[0] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_eq("bp_s_ready_low", 32'(s_ready[0]), 32'd0);
      chk_eq("bp_hold_data", 32'(m_data[0]), 32'h4321);
      chk_eq("bp_hold_valid", 32'(m_valid[0]), 32'd1);
      @(posedge clk);
      #2;
    end
    m_ready[0] = 1'b1;
    #1;
    chk_eq("bp_s_ready_up", 32'(s_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    s_valid[0] = 1'b0;
    chk_eq("bp_second_valid", 32'(m_valid[0]), 32'd1);
    chk_eq("bp_second_data", 32'(m_data[0]), 32'h8765);
    chk_eq("bp_lane_cnt_clr", 32'(lane_cnt[0]), 32'd0);
    idle_cycle();

    // Reset in the middle of a word
    beat(0, 4'h1, 1'b0, w);
    beat(0, 4'h2, 1'b0, w);
    rstn = 1'b0;
    #2;
    chk_eq("mid_rst_valid", 32'(m_valid[0]), 32'd0);
    chk_eq("mid_rst_lane_cnt", 32'(lane_cnt[0]), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    beat(0, 4'h5, 1'b0, w);
    beat(0, 4'h6, 1'b0, w);
    beat(0, 4'h7, 1'b0, w);
    chk_eq("post_rst_no_word", 32'(m_valid[0]), 32'd0);
    beat(0, 4'h8, 1'b0, w);
    chk_eq("post_rst_valid", 32'(m_valid[0]), 32'd1);
    chk_eq("post_rst_data", 32'(m_data[0]), 32'h8765);
    chk_eq("post_rst_keep", 32'(m_keep[0]), 32'hF);

    // Single-beat packet, then s_last on the final lane
    beat(0, 4'h9, 1'b1, w);
    chk_eq("single_data", 32'(m_data[0]), 32'h0009);
    chk_eq("single_keep", 32'(m_keep[0]), 32'h1);
    chk_eq("single_last", 32'(m_last[0]), 32'd1);
    beat(0, 4'h1, 1'b0, w);
    beat(0, 4'h2, 1'b0, w);
    beat(0, 4'h3, 1'b0, w);
    beat(0, 4'h4, 1'b1, w);
    chk_eq("edge_last_data", 32'(m_data[0]), 32'h4321);
    chk_eq("edge_last_keep", 32'(m_keep[0]), 32'hF);
    chk_eq("edge_last_last", 32'(m_last[0]), 32'd1);
    beat(1, 4'h9, 1'b1, w);
    chk_eq("msb_single_data", 32'(m_data[1]), 32'h9000);
    chk_eq("msb_single_keep", 32'(m_keep[1]), 32'h8);
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
